// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one AES-128 core between two requesters: capture PT, run the core, return CT.
// Core is held in reset outside RUN; a RUN-cycle counter aborts a transaction whose core never reports ready.
module aes_core_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Req0,
    input  logic         Req1,
    input  logic [127:0] PT0,
    input  logic [127:0] PT1,
    output logic         Ack0,
    output logic         Ack1,
    output logic         Done0,
    output logic         Done1,
    output logic         Err,
    output logic [127:0] CT_out,
    output logic         Busy,
    output logic         Owner,
    output logic         Core_Rst,
    output logic         Core_En,
    output logic [127:0] Core_PT,
    input  logic         Core_Ry,
    input  logic [127:0] Core_CT
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ls_q, ls_d;
    logic               owner_q, owner_d;
    logic [127:0]       core_pt_q, core_pt_d;
    logic [127:0]       ct_q, ct_d;
    logic               ack0_q, ack0_d, ack1_q, ack1_d;
    logic               done0_q, done0_d, done1_q, done1_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               core_rst_q, core_rst_d;
    logic               core_en_q, core_en_d;
    logic               grant;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ls_d      = ls_q;
        owner_d   = owner_q;
        core_pt_d = core_pt_q;
        ct_d      = ct_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;
        grant     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req0 || Req1) begin
                    // On a tie the requester not served last time wins.
                    grant     = (Req0 && Req1) ? ~ls_q : Req1;
                    owner_d   = grant;
                    ls_d      = grant;
                    core_pt_d = grant ? PT1 : PT0;
                    ack0_d    = ~grant;
                    ack1_d    = grant;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (Core_Ry) begin
                    ct_d    = Core_CT;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Err doubles as the timeout flag; it lives exactly for the DONE cycle.
                    ct_d    = '0;
                    err_d   = 1'b1;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        core_rst_d = (state_d != S_RUN);
        core_en_d  = (state_d == S_RUN);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ls_q       <= 1'b1;
            owner_q    <= 1'b0;
            core_pt_q  <= '0;
            ct_q       <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ls_q       <= ls_d;
            owner_q    <= owner_d;
            core_pt_q  <= core_pt_d;
            ct_q       <= ct_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            core_rst_q <= core_rst_d;
            core_en_q  <= core_en_d;
        end
    end

    assign Ack0     = ack0_q;
    assign Ack1     = ack1_q;
    assign Done0    = done0_q;
    assign Done1    = done1_q;
    assign Err      = err_q;
    assign CT_out   = ct_q;
    assign Busy     = busy_q;
    assign Owner    = owner_q;
    assign Core_Rst = core_rst_q;
    assign Core_En  = core_en_q;
    assign Core_PT  = core_pt_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a behavioural core of programmable latency.
module tb_aes_core_arbiter;

    localparam logic [127:0] KPT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KCT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] XMASK = {16{8'ha5}};

    logic         clk, rst, req0, req1;
    logic [127:0] pt0, pt1;
    logic         ack0, ack1, done0, done1, err, busy, owner;
    logic [127:0] ct_out, core_pt, core_ct;
    logic         core_rst, core_en, core_ry;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat   = 0;
    logic [7:0] mcnt;

    aes_core_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .Clk(clk), .Rst(rst), .Req0(req0), .Req1(req1), .PT0(pt0), .PT1(pt1),
        .Ack0(ack0), .Ack1(ack1), .Done0(done0), .Done1(done1), .Err(err),
        .CT_out(ct_out), .Busy(busy), .Owner(owner), .Core_Rst(core_rst),
        .Core_En(core_en), .Core_PT(core_pt), .Core_Ry(core_ry), .Core_CT(core_ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: the FIPS-197 vector for key 000102..0f, otherwise PT xor a mask.
    function automatic logic [127:0] core_fn(input logic [127:0] p);
        return (p == KPT) ? KCT : (p ^ XMASK);
    endfunction
    assign core_ct = core_fn(core_pt);

    // Ry is first sampled high by the arbiter in RUN cycle 'lat'; lat==0 means never.
    always @(posedge clk) begin
        if (core_rst === 1'b1) begin
            mcnt    <= '0;
            core_ry <= 1'b0;
        end else if (core_en === 1'b1) begin
            mcnt <= mcnt + 8'd1;
            if (lat > 1 && int'(mcnt) + 1 >= lat - 1) core_ry <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Bounded wait for a Done pulse (want_done=1) or an Ack pulse; at=-1 on expiry.
    task automatic wait_for(input bit want_done, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (want_done ? (done0 | done1) : (ack0 | ack1)) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int ge, at, prev_ack;
        logic [127:0] exp_ct;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; pt0 = '0; pt1 = '0;
        tick(); tick();
        chk("rst_ctl", {ack0, ack1, done0, done1, err, busy, owner, core_rst, core_en}, 9'b000000010);
        chk("rst_pt", core_pt, 128'h0);
        chk("rst_ct", ct_out, 128'h0);
        rst = 1'b0;
        tick();

        // Single request on port 0; PT0 changes right after Ack.
        lat = 3; req0 = 1'b1; pt0 = KPT;
        tick(); ge = cyc;
        chk("t1_ack", {ack0, ack1, busy, core_rst, owner}, 5'b10110);
        chk("t1_core_pt", core_pt, KPT);
        req0 = 1'b0; pt0 = 128'hdeadbeef;
        tick();
        chk("t1_run", {ack0, core_rst, core_en, busy}, 4'b0011);
        wait_for(1'b1, at);
        chk("t1_lat", at - ge, 4);
        chk("t1_done", {done0, done1, err}, 3'b100);
        chk("t1_ct", ct_out, KCT);
        tick();
        chk("t1_after", {done0, done1, busy, core_rst}, 4'b0001);
        chk("t1_ct_hold", ct_out, KCT);

        // Requester 1 alone, 5-cycle core.
        lat = 5; req1 = 1'b1; pt1 = 128'h0123456789abcdef0011223344556677;
        tick(); ge = cyc;
        chk("t2_ack", {ack0, ack1, owner}, 3'b011);
        req1 = 1'b0;
        wait_for(1'b1, at);
        chk("t2_lat", at - ge, 6);
        chk("t2_done", {done0, done1, err}, 3'b010);
        chk("t2_ct", ct_out, 128'h0123456789abcdef0011223344556677 ^ XMASK);
        tick();
        chk("t2_idle", busy, 1'b0);

        // Both held: grants alternate 0,1,0,1 with k+3 spacing.
        lat = 2; req0 = 1'b1; req1 = 1'b1;
        pt0 = 128'h11111111222222223333333344444444;
        pt1 = 128'h55555555666666667777777788888888;
        prev_ack = 0;
        for (int i = 0; i < 4; i++) begin
            wait_for(1'b0, at);
            chk("t3_grant", {ack1, ack0}, (i % 2) ? 2'b10 : 2'b01);
            if (i > 0) chk("t3_gap", at - prev_ack, 5);
            prev_ack = at;
            wait_for(1'b1, at);
            exp_ct = (i % 2) ? (pt1 ^ XMASK) : (pt0 ^ XMASK);
            chk("t3_owner", {done1, done0}, (i % 2) ? 2'b10 : 2'b01);
            chk("t3_ct", ct_out, exp_ct);
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
        tick(); tick();

        // Timeout with a core that never answers, then a normal transaction.
        lat = 0; req0 = 1'b1; pt0 = 128'hcafef00d;
        tick(); ge = cyc;
        chk("t4_ack", ack0, 1'b1);
        req0 = 1'b0;
        wait_for(1'b1, at);
        chk("t4_lat", at - ge, 17);
        chk("t4_done_err", {done0, done1, err}, 3'b101);
        chk("t4_ct", ct_out, 128'h0);
        tick();
        chk("t4_err_pulse", {err, done0}, 2'b00);
        lat = 2; req1 = 1'b1; pt1 = 128'h77;
        tick(); ge = cyc;
        chk("t4b_ack", ack1, 1'b1);
        req1 = 1'b0;
        wait_for(1'b1, at);
        chk("t4b_lat", at - ge, 3);
        chk("t4b_done", {done0, done1, err}, 3'b010);
        chk("t4b_ct", ct_out, 128'h77 ^ XMASK);
        tick();

        // Reset during RUN cycle 3 aborts silently; LS returns to favour requester 0.
        lat = 0; req0 = 1'b1; pt0 = 128'h99;
        tick();
        req0 = 1'b0;
        tick(); tick(); tick();
        chk("t5_in_run", core_en, 1'b1);
        rst = 1'b1;
        tick();
        chk("t5_abort", {done0, done1, err, busy, core_rst, core_en}, 6'b000010);
        chk("t5_ct", ct_out, 128'h0);
        rst = 1'b0;
        lat = 2; req0 = 1'b1; req1 = 1'b1; pt0 = KPT;
        tick();
        chk("t5_tie", {ack0, ack1}, 2'b10);
        req0 = 1'b0; req1 = 1'b0;
        wait_for(1'b1, at);
        chk("t5_done", {done0, done1, err}, 3'b100);
        chk("t5_ct_after", ct_out, KCT);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
